clock_set_ctrl: RTL and testbench

//  Mode/edit controller for the digital clock's hour/minute/second counters.

---
 rtl/clock_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/clock_set_ctrl.sv | 156 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings for the clock set controller: FSM state codes and one-hot edit field selects.
package clock_pkg;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t ST_RUN    = 2'd0;
    localparam ctrl_state_t ST_SET_HR = 2'd1;
    localparam ctrl_state_t ST_SET_MI = 2'd2;
    localparam ctrl_state_t ST_SET_SE = 2'd3;

    localparam logic [2:0] EDIT_NONE = 3'b000;
    localparam logic [2:0] EDIT_HR   = 3'b100;
    localparam logic [2:0] EDIT_MI   = 3'b010;
    localparam logic [2:0] EDIT_SE   = 3'b001;

    function automatic logic [2:0] edit_sel_of(input ctrl_state_t st);
        case (st)
            ST_SET_HR: edit_sel_of = EDIT_HR;
            ST_SET_MI: edit_sel_of = EDIT_MI;
            ST_SET_SE: edit_sel_of = EDIT_SE;
            default:   edit_sel_of = EDIT_NONE;
        endcase
    endfunction

    function automatic ctrl_state_t next_field(input ctrl_state_t st);
        case (st)
            ST_RUN:    next_field = ST_SET_HR;
            ST_SET_HR: next_field = ST_SET_MI;
            ST_SET_MI: next_field = ST_SET_SE;
            default:   next_field = ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability down-counter and press (1->0) edge pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // cnt_q reaches zero on the DEB_CYCLES-th consecutive sample that differs from level_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= DEB_LOAD;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            press_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= DEB_LOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync_q[1];
                press_q <= ~sync_q[1];
                cnt_q   <= DEB_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign btn_level = level_q;
    assign press     = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/edit controller: turns debounced mode/up/down buttons into counter enables,
// one-cycle active-low step strobes and the one-hot edit field select.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_RUN    | clock running, up/down ignored
//   ST_SET_HR | clock frozen, up/down step the hour counter
//   ST_SET_MI | clock frozen, up/down step the minute counter
//   ST_SET_SE | clock frozen, up/down step the second counter
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TIMEOUT_S  = 10,
    parameter int REPEAT_S   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_1s,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       enable_cnt_hr,
    output logic       enable_cnt_mi,
    output logic       enable_cnt_se,
    output logic       increase_hr,
    output logic       increase_mi,
    output logic       increase_se,
    output logic       decrease_hr,
    output logic       decrease_mi,
    output logic       decrease_se,
    output logic [2:0] edit_sel
);
    localparam int TO_W = $clog2(TIMEOUT_S + 1);
    localparam int RP_W = (REPEAT_S > 1) ? $clog2(REPEAT_S) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_S);
    localparam logic [RP_W-1:0] RPT_LAST = RP_W'(REPEAT_S - 1);

    logic mode_lvl, up_lvl, dn_lvl;
    logic mode_press, up_press, dn_press;

    ctrl_state_t     state, next_state;
    logic [TO_W-1:0] to_cnt;
    logic [RP_W-1:0] rpt_cnt;

    logic in_set, up_held, dn_held, one_held, any_held;
    logic to_hit, rpt_fire, state_chg, step_up, step_dn;

    logic       en_d;
    logic [2:0] sel_d, inc_d, dec_d;
    logic       en_q;
    logic [2:0] sel_q, inc_q, dec_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst), .btn_raw(btn_mode), .btn_level(mode_lvl), .press(mode_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst), .btn_raw(btn_up), .btn_level(up_lvl), .press(up_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk(clk), .rst(rst), .btn_raw(btn_down), .btn_level(dn_lvl), .press(dn_press)
    );

    assign in_set   = (state != ST_RUN);
    assign up_held  = ~up_lvl;
    assign dn_held  = ~dn_lvl;
    assign one_held = up_held ^ dn_held;
    // A press event always coincides with its level going low, so "held" covers
    // "pressed"; a held button also keeps the edit session from timing out.
    assign any_held = ~mode_lvl | up_held | dn_held;
    assign to_hit   = (to_cnt == TO_LAST);
    assign rpt_fire = pulse_1s && in_set && one_held && (rpt_cnt >= RPT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (mode_press) begin
            next_state = next_field(state);
        end else if (in_set && to_hit && !any_held) begin
            next_state = ST_RUN;
        end
    end

    assign state_chg = (next_state != state);
    assign step_up = in_set && !state_chg && !(up_held && dn_held) &&
                     (up_press || (rpt_fire && up_held));
    assign step_dn = in_set && !state_chg && !(up_held && dn_held) &&
                     (dn_press || (rpt_fire && dn_held));

    always_comb begin
        en_d  = (next_state == ST_RUN);
        sel_d = edit_sel_of(next_state);
        inc_d = 3'b111;
        dec_d = 3'b111;
        if (step_up) begin
            inc_d = ~edit_sel_of(state);
        end
        if (step_dn) begin
            dec_d = ~edit_sel_of(state);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (!in_set || any_held || state_chg) begin
            to_cnt <= '0;
        end else if (pulse_1s && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Saturates at REPEAT_S-1 so every later tick keeps firing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt <= '0;
        end else if (!in_set || !one_held) begin
            rpt_cnt <= '0;
        end else if (pulse_1s && (rpt_cnt < RPT_LAST)) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q  <= 1'b1;
            sel_q <= EDIT_NONE;
            inc_q <= 3'b111;
            dec_q <= 3'b111;
        end else begin
            en_q  <= en_d;
            sel_q <= sel_d;
            inc_q <= inc_d;
            dec_q <= dec_d;
        end
    end

    assign enable_cnt_hr = en_q;
    assign enable_cnt_mi = en_q;
    assign enable_cnt_se = en_q;
    assign increase_hr   = inc_q[2];
    assign increase_mi   = inc_q[1];
    assign increase_se   = inc_q[0];
    assign decrease_hr   = dec_q[2];
    assign decrease_mi   = dec_q[1];
    assign decrease_se   = dec_q[0];
    assign edit_sel      = sel_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/timeout/repeat settings.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pulse_1s = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_up = 1'b1;
    logic       btn_down = 1'b1;
    logic       enable_cnt_hr, enable_cnt_mi, enable_cnt_se;
    logic       increase_hr, increase_mi, increase_se;
    logic       decrease_hr, decrease_mi, decrease_se;
    logic [2:0] edit_sel;

    int n_checks = 0;
    int n_errors = 0;
    int inc_n[3] = '{default: 0};
    int dec_n[3] = '{default: 0};
    int multi_low = 0;
    int long_low = 0;
    int run_low = 0;
    int cnt_mi = 59;
    logic [5:0] prev_low = 6'b0;
    int snap;

    clock_set_ctrl #(.DEB_CYCLES(4), .TIMEOUT_S(3), .REPEAT_S(2)) dut (
        .clk(clk), .rst(rst), .pulse_1s(pulse_1s),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .enable_cnt_hr(enable_cnt_hr), .enable_cnt_mi(enable_cnt_mi), .enable_cnt_se(enable_cnt_se),
        .increase_hr(increase_hr), .increase_mi(increase_mi), .increase_se(increase_se),
        .decrease_hr(decrease_hr), .decrease_mi(decrease_mi), .decrease_se(decrease_se),
        .edit_sel(edit_sel)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample outputs at the falling edge and update the strobe tallies
    // and the bench's own minute counter model.
    task automatic step();
        logic [2:0] inc_l, dec_l;
        logic [5:0] all_l;
        @(negedge clk);
        inc_l = ~{increase_hr, increase_mi, increase_se};
        dec_l = ~{decrease_hr, decrease_mi, decrease_se};
        all_l = {inc_l, dec_l};
        if ($countones(all_l) > 1) multi_low++;
        if ((all_l & prev_low) != 6'b0) long_low++;
        if (all_l != 6'b0 && edit_sel == 3'b000) run_low++;
        for (int i = 0; i < 3; i++) begin
            if (inc_l[i]) inc_n[i]++;
            if (dec_l[i]) dec_n[i]++;
        end
        if (inc_l[1]) cnt_mi = (cnt_mi == 59) ? 0 : cnt_mi + 1;
        if (dec_l[1]) cnt_mi = (cnt_mi == 0) ? 59 : cnt_mi - 1;
        prev_low = all_l;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Ticks every 20 cycles
    task automatic run_ticks(input int n);
        repeat (n) begin
            steps(19);
            pulse_1s = 1'b1;
            step();
            pulse_1s = 1'b0;
        end
    endtask

    // which: 0 mode, 1 up, 2 down, 3 up+down
    task automatic press(input int which, input int hold);
        case (which)
            0: btn_mode = 1'b0;
            1: btn_up = 1'b0;
            2: btn_down = 1'b0;
            default: begin btn_up = 1'b0; btn_down = 1'b0; end
        endcase
        steps(hold);
        btn_mode = 1'b1;
        btn_up = 1'b1;
        btn_down = 1'b1;
        steps(10);
    endtask

    task automatic check_mode(input string tag, input logic [2:0] exp_sel);
        check_val({tag, "_sel"}, 32'(edit_sel), 32'(exp_sel));
        check_val({tag, "_en"}, 32'({enable_cnt_hr, enable_cnt_mi, enable_cnt_se}),
                  (exp_sel == 3'b000) ? 7 : 0);
    endtask

    function automatic int all_strobes();
        return inc_n[0] + inc_n[1] + inc_n[2] + dec_n[0] + dec_n[1] + dec_n[2];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        steps(3);
        rst = 1'b1;

        // idle after reset
        run_ticks(5);
        check_mode("reset", 3'b000);
        check_val("reset_strobes",
                  32'({increase_hr, increase_mi, increase_se, decrease_hr, decrease_mi, decrease_se}), 63);

        // mode cycling
        press(0, 10); check_mode("m_hr", 3'b100);
        press(0, 10); check_mode("m_mi", 3'b010);
        press(0, 10); check_mode("m_se", 3'b001);
        press(0, 10); check_mode("m_run", 3'b000);

        // minute step with wrap, via the bench minute model
        press(0, 10); press(0, 10); check_mode("mi_enter", 3'b010);
        snap = inc_n[1];
        press(1, 10);
        check_val("mi_up_cycles", inc_n[1] - snap, 1);
        check_val("mi_up_wrap", cnt_mi, 0);
        snap = dec_n[1];
        press(2, 10);
        check_val("mi_dn_cycles", dec_n[1] - snap, 1);
        check_val("mi_dn_wrap", cnt_mi, 59);

        // up/down ignored in RUN
        press(0, 10); press(0, 10); check_mode("back_run", 3'b000);
        snap = all_strobes();
        press(1, 10);
        press(2, 10);
        check_val("run_ignore", all_strobes() - snap, 0);
        check_mode("run_stay", 3'b000);

        // short glitch in SET_HR
        press(0, 10); check_mode("g_hr", 3'b100);
        snap = all_strobes();
        btn_up = 1'b0; steps(2); btn_up = 1'b1; steps(20);
        check_val("glitch_strobes", all_strobes() - snap, 0);
        check_mode("glitch_state", 3'b100);

        // held up over 5 ticks: press strobe plus repeats on ticks 2..5
        snap = inc_n[2];
        btn_up = 1'b0; steps(10);
        run_ticks(5);
        btn_up = 1'b1; steps(10);
        check_val("repeat_count", inc_n[2] - snap, 5);
        check_mode("repeat_state", 3'b100);

        // up+down together
        snap = all_strobes();
        btn_up = 1'b0; btn_down = 1'b0; steps(10);
        run_ticks(2);
        btn_up = 1'b1; btn_down = 1'b1; steps(10);
        check_val("both_strobes", all_strobes() - snap, 0);
        check_mode("both_state", 3'b100);

        // timeout from SET_SE
        press(0, 10); press(0, 10); check_mode("to_se", 3'b001);
        run_ticks(2);
        check_mode("to_wait", 3'b001);
        run_ticks(1); steps(3);
        check_mode("to_run", 3'b000);

        // press lands on the third tick: stays, timeout restarts
        press(0, 10); press(0, 10); press(0, 10); check_mode("tp_se", 3'b001);
        run_ticks(2);
        snap = inc_n[0];
        btn_up = 1'b0;
        steps(6);
        pulse_1s = 1'b1;
        step();
        pulse_1s = 1'b0;
        steps(5);
        btn_up = 1'b1; steps(10);
        check_mode("tp_stay", 3'b001);
        check_val("tp_strobe", inc_n[0] - snap, 1);
        run_ticks(2);
        check_mode("tp_restart", 3'b001);
        run_ticks(1); steps(3);
        check_mode("tp_run", 3'b000);

        // reset mid-edit
        press(0, 10); press(0, 10); check_mode("r_mi", 3'b010);
        #2 rst = 1'b0;
        #1;
        check_mode("r_abort", 3'b000);
        check_val("r_strobes",
                  32'({increase_hr, increase_mi, increase_se, decrease_hr, decrease_mi, decrease_se}), 63);
        steps(3);
        rst = 1'b1;
        steps(5);
        check_mode("r_after", 3'b000);

        check_val("strobe_multi", multi_low, 0);
        check_val("strobe_width", long_low, 0);
        check_val("strobe_in_run", run_low, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
